// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC vector geometry and sequencer state encoding
package mac_pkg;

  localparam int LANES   = 16;
  localparam int LANE_W  = 8;
  localparam int VEC_W   = LANES * LANE_W;
  localparam int SUM_W   = 20;
  localparam int MAC_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mac_chunk_sequencer_if.sv
// rtl/mac_chunk_sequencer_if.sv - memory read, MAC feed and result handshake bundle
interface mac_chunk_sequencer_if
  import mac_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 26
);

  logic              mem_en;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic [VEC_W-1:0]  pix_data;
  logic [VEC_W-1:0]  wgt_data;
  logic [VEC_W-1:0]  mac_pixels;
  logic [VEC_W-1:0]  mac_weights;
  logic [SUM_W-1:0]  mac_sum;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output mem_en, pix_addr, wgt_addr, mac_pixels, mac_weights, result, result_valid,
    input  pix_data, wgt_data, mac_sum, result_ready
  );

  modport slave (
    input  mem_en, pix_addr, wgt_addr, mac_pixels, mac_weights, result, result_valid,
    output pix_data, wgt_data, mac_sum, result_ready
  );

endinterface

// File: rtl/mac_valid_pipe.sv
// rtl/mac_valid_pipe.sv - 1-bit valid shift register with sync clear, tail and occupancy flags
module mac_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  output logic [DEPTH-1:0] stages,
  output logic             tail,
  output logic             any
);

  logic [DEPTH-1:0] q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else begin
      q <= {q[DEPTH-2:0], din};
    end
  end

  assign stages = q;
  assign tail   = q[DEPTH-1];
  assign any    = |q;

endmodule

// File: rtl/mac_chunk_sequencer.sv
// rtl/mac_chunk_sequencer.sv - streams NUM_CHUNKS memory word pairs into the MAC and accumulates one neuron
module mac_chunk_sequencer
  import mac_pkg::*;
#(
  parameter int NUM_CHUNKS = 49,
  parameter int ADDR_W     = 10,
  parameter int MEM_LAT    = 1,
  parameter int MAC_LAT    = mac_pkg::MAC_LAT,
  parameter int ACC_W      = 26
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] pix_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              busy,
  mac_chunk_sequencer_if.master bus
);

  localparam int PIPE_D = MEM_LAT + MAC_LAT;
  localparam int CNT_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [PIPE_D-1:0] stages;
  logic              tail;
  logic              any;
  logic              data_valid;

  mac_valid_pipe #(.DEPTH(PIPE_D)) u_valid_pipe (
    .clk    (clk),
    .resetn (resetn),
    .din    (bus.mem_en),
    .stages (stages),
    .tail   (tail),
    .any    (any)
  );

  // Memory data is live exactly MEM_LAT cycles after its read enable.
  assign data_valid      = stages[MEM_LAT-1];
  assign bus.mac_pixels  = data_valid ? bus.pix_data : '0;
  assign bus.mac_weights = data_valid ? bus.wgt_data : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      busy             <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.pix_addr     <= '0;
      bus.wgt_addr     <= '0;
      cnt              <= '0;
      acc              <= '0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      if (tail) begin
        acc <= acc + ACC_W'(bus.mac_sum);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            bus.mem_en   <= 1'b1;
            bus.pix_addr <= pix_base;
            bus.wgt_addr <= wgt_base;
            cnt          <= '0;
            acc          <= '0;
          end
        end
        ISSUE: begin
          if (cnt == LAST) begin
            bus.mem_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            cnt          <= cnt + CNT_W'(1);
            bus.pix_addr <= bus.pix_addr + ADDR_W'(1);
            bus.wgt_addr <= bus.wgt_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // The last tail bit has already been folded into acc once the pipe reads empty.
          if (!any) begin
            bus.result       <= acc;
            bus.result_valid <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_chunk_sequencer.sv
// tb/tb_mac_chunk_sequencer.sv - directed scoreboard bench with memory and MAC models
module tb_mac_chunk_sequencer;
  import mac_pkg::*;

  localparam int NUM_CHUNKS = 49;
  localparam int ADDR_W     = 10;
  localparam int ACC_W      = 26;
  localparam int MEM_DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] pix_base;
  logic [ADDR_W-1:0] wgt_base;
  logic              busy;

  always #5 clk = ~clk;

  mac_chunk_sequencer_if #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

  mac_chunk_sequencer #(
    .NUM_CHUNKS (NUM_CHUNKS),
    .ADDR_W     (ADDR_W),
    .MEM_LAT    (1),
    .MAC_LAT    (3),
    .ACC_W      (ACC_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .pix_base (pix_base),
    .wgt_base (wgt_base),
    .busy     (busy),
    .bus      (bus.master)
  );

  logic [VEC_W-1:0] pix_mem [MEM_DEPTH];
  logic [VEC_W-1:0] wgt_mem [MEM_DEPTH];
  logic [VEC_W-1:0] pix_q = '0;
  logic [VEC_W-1:0] wgt_q = '0;
  logic [SUM_W-1:0] m1 = '0, m2 = '0, m3 = '0;
  int               cyc_now = 0;

  function automatic logic [SUM_W-1:0] lane_dot(input logic [VEC_W-1:0] p, input logic [VEC_W-1:0] w);
    logic [SUM_W-1:0] s = '0;
    for (int l = 0; l < LANES; l++) begin
      s += SUM_W'(p[VEC_W-1-LANE_W*l -: LANE_W]) * SUM_W'(w[VEC_W-1-LANE_W*l -: LANE_W]);
    end
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] ref_dot(input int pb, input int wb);
    logic [ACC_W-1:0] s = '0;
    for (int n = 0; n < NUM_CHUNKS; n++) begin
      s += ACC_W'(lane_dot(pix_mem[(pb + n) % MEM_DEPTH], wgt_mem[(wb + n) % MEM_DEPTH]));
    end
    return s;
  endfunction

  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (bus.mem_en) begin
      pix_q <= pix_mem[bus.pix_addr];
      wgt_q <= wgt_mem[bus.wgt_addr];
    end
    m1 <= lane_dot(bus.mac_pixels, bus.mac_weights);
    m2 <= m1;
    m3 <= m2;
  end

  assign bus.pix_data = pix_q;
  assign bus.wgt_data = wgt_q;
  assign bus.mac_sum  = m3;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [ACC_W-1:0] exp_q[$];
  int               cur_pb;
  int               cur_wb;
  int               t_a;
  int               t_b;
  int               t_x;
  int               issued;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_mem_en"}, 64'(bus.mem_en), 64'd0);
    check({tag, "_result_valid"}, 64'(bus.result_valid), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_mac_pixels"}, 64'(|bus.mac_pixels), 64'd0);
    check({tag, "_mac_weights"}, 64'(|bus.mac_weights), 64'd0);
    check({tag, "_pix_addr"}, 64'(bus.pix_addr), 64'd0);
    check({tag, "_wgt_addr"}, 64'(bus.wgt_addr), 64'd0);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic start_neuron(input int pb, input int wb, input logic [ACC_W-1:0] exp);
    pix_base = ADDR_W'(pb);
    wgt_base = ADDR_W'(wb);
    start    = 1'b1;
    cur_pb   = pb;
    cur_wb   = wb;
    exp_q.push_back(exp);
  endtask

  task automatic wait_result(input int hold, input bit poke, output int t_valid);
    int               cyc = 0;
    int               idx = 0;
    bit               seen = 0;
    logic [ACC_W-1:0] exp = '0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("busy_rise", 64'(busy), 64'd1);
      if (bus.mem_en) begin
        check("pix_addr", 64'(bus.pix_addr), 64'((cur_pb + idx) % MEM_DEPTH));
        check("wgt_addr", 64'(bus.wgt_addr), 64'((cur_wb + idx) % MEM_DEPTH));
        idx++;
      end
      if (bus.result_valid) seen = 1;
    end
    t_valid = cyc_now;
    check("latency", 64'(cyc), 64'd55);
    check("issue_count", 64'(idx), 64'(NUM_CHUNKS));
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check("result", 64'(bus.result), 64'(exp));
    if (!seen) return;
    bus.result_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 3) begin
        start    = 1'b1;
        pix_base = ADDR_W'(100);
        wgt_base = ADDR_W'(200);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("hold_result", 64'(bus.result), 64'(exp));
      check("hold_valid", 64'(bus.result_valid), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
    end
    start            = 1'b0;
    bus.result_ready = 1'b1;
    if (hold > 0) @(negedge clk);
    else          @(negedge clk);
    bus.result_ready = 1'b0;
    check("post_hs_valid", 64'(bus.result_valid), 64'd0);
    check("post_hs_busy", 64'(busy), 64'd0);
    if (poke) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("ignored_start_mem_en", 64'(bus.mem_en), 64'd0);
        check("ignored_start_busy", 64'(busy), 64'd0);
      end
    end
  endtask

  initial begin
    resetn           = 1'b0;
    start            = 1'b0;
    pix_base         = '0;
    wgt_base         = '0;
    bus.result_ready = 1'b0;
    for (int a = 0; a < MEM_DEPTH; a++) begin
      pix_mem[a] = '0;
      wgt_mem[a] = '0;
    end
    for (int n = 0; n < NUM_CHUNKS; n++) begin
      pix_mem[100 + n] = '1;
      wgt_mem[200 + n] = '1;
      pix_mem[300 + n] = {LANES{8'(n)}};
      wgt_mem[400 + n] = {LANES{8'h01}};
      pix_mem[(10'h3F0 + n) % MEM_DEPTH] = {$urandom(), $urandom(), $urandom(), $urandom()};
      wgt_mem[n] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Saturated lanes, ready already high when the result appears.
    start_neuron(100, 200, 26'd50979600);
    wait_result(0, 0, t_x);

    // Ramp pixels against unit weights.
    start_neuron(300, 400, 26'd18816);
    wait_result(0, 0, t_x);

    // Pixel address wraps through 0x3FF.
    start_neuron(10'h3F0, 0, ref_dot(10'h3F0, 0));
    wait_result(0, 0, t_x);

    // Backpressure with a stray start inside the hold window.
    start_neuron(300, 400, 26'd18816);
    wait_result(10, 1, t_x);

    // One-cycle reset during chunk 20, then an immediate fresh neuron.
    start_neuron(10'h3F0, 0, ref_dot(10'h3F0, 0));
    issued = 0;
    for (int c = 0; c < 100 && issued <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_en) issued++;
    end
    check("abort_reached_chunk20", 64'(bus.pix_addr), 64'((10'h3F0 + 20) % MEM_DEPTH));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs("abort");
    void'(exp_q.pop_back());
    start_neuron(300, 400, 26'd18816);
    wait_result(0, 0, t_x);

    // Back-to-back neurons with start right after the handshake.
    start_neuron(100, 200, 26'd50979600);
    wait_result(0, 0, t_a);
    start_neuron(10'h3F0, 0, ref_dot(10'h3F0, 0));
    wait_result(0, 0, t_b);
    check("b2b_spacing", 64'(t_b - t_a), 64'd56);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
